regbank_exec_ctrl: RTL and testbench
====================================

// Module: regbank_exec_ctrl
// PURPOSE
//  Register bank plus execute sequencer that sits directly upstream of the ALU.
//  It accepts one R-type op per valid/ready handshake, reads two operands from a
//  16x32 register bank and drives the ALU's a/b/shamt/funct inputs.
//  It then waits for the ALU's registered result and writes it back to rd.
//  A load/debug port preloads registers and inspects them.
// PARAMETERS
//  NREG   16  number of registers (address width = $clog2(NREG) = 4)
//  DW     32  register/data width; must match ALU operand width
//  MAXFN  8   highest legal funct code (ADD=0 SUB=1 AND=2 OR=3 XOR=4 NOT=5 SLA=6 SRA=7 SRL=8)
// PORTS
//  clk          in   1   single clock, all state on posedge
//  rst          in   1   synchronous, active-high reset
//  instr_valid  in   1   op fields below are valid
//  instr_ready  out  1   block can accept an op (high only in IDLE)
//  rs           in   4   source register for ALU a
//  rt           in   4   source register for ALU b
//  rd           in   4   destination register
//  funct_in     in   6   ALU operation code
//  shamt_in     in   5   shift amount passed to ALU
//  alu_a        out  DW  registered operand a to ALU
//  alu_b        out  DW  registered operand b to ALU
//  alu_shamt    out  5   registered shamt to ALU
//  alu_funct    out  6   registered funct to ALU
//  alu_res      in   DW  ALU result (ALU registers it on posedge clk)
//  done         out  1   one-cycle pulse: writeback completed
//  err          out  1   one-cycle pulse: op rejected (illegal funct)
//  ext_we       in   1   external register write enable (honoured in IDLE only)
//  ext_waddr    in   4   external write address
//  ext_wdata    in   DW  external write data
//  dbg_raddr    in   4   debug read address
//  dbg_rdata    out  DW  combinational read of R[dbg_raddr]
// BEHAVIOUR
//  - Reset (sync, rst=1 at posedge): all R[i]=0; alu_a=alu_b=0; alu_shamt=0;
//    alu_funct=0; done=0; err=0; state=IDLE.
//  - Reset mid-operation aborts the op. No writeback and no done pulse occur.
//  - FSM states: IDLE -> READ -> EXEC -> WB -> IDLE.
//  - IDLE: instr_ready=1.
//    - On instr_valid at the edge, latch rs/rt/rd/funct_in/shamt_in.
//    - If funct_in > MAXFN: pulse err next cycle, stay IDLE, no register change.
//    - Otherwise go to READ.
//  - READ: at the edge, drive alu_a<=R[rs], alu_b<=R[rt], alu_shamt, alu_funct;
//    go to EXEC.
//  - EXEC: ALU inputs held stable; the ALU captures its result at this edge;
//    go to WB.
//  - WB: at the edge, write R[rd]<=alu_res, set done=1 for exactly one cycle,
//    go to IDLE.
//  - Latency: accept at edge T -> R[rd] updated at edge T+3 -> done high in cycle
//    after T+3. Throughput: one op per 4 cycles.
//  - alu_* outputs hold their last value outside READ. They are never changed in
//    EXEC or WB.
//  - ext_we:
//    - Applied only when state==IDLE.
//    - Ignored (no write) in READ/EXEC/WB.
//    - An ext write and an instr accept in the same IDLE cycle are both taken;
//      the op's READ sees the new value.
//  - rd==rs or rd==rt: operands are read in READ, before the WB write (no hazard).
//  - No hardwired zero register; R0 is an ordinary register.
//  - Arithmetic is performed solely by the ALU. This block does no width
//    conversion; data is DW bits end to end.
//  - done and err are never high in the same cycle.
// TESTING
//  1. rst held 2 cycles -> dbg_rdata=0 for all 16 addrs; instr_ready=1; done=0; err=0.
//  2. ext write R1=5, R2=3; ADD rs=1 rt=2 rd=3 -> alu_a=5, alu_b=3 after READ;
//     R3=8 at T+3; done single pulse.
//  3. R4=0xFFFF_FFF0; SRA rs=4 shamt=2 rd=5 -> R5=0xFFFF_FFFC.
//     SRL same -> R5=0x3FFF_FFFC.
//  4. funct_in=9 with valid -> err pulse; instr_ready stays 1; all registers unchanged.
//  5. SUB rs=rd=6 (R6=10, R7=4) -> R6=6. Back-to-back valid held high ->
//     second op accepted exactly 4 cycles after the first.
//  6. rst asserted in EXEC of ADD into rd=9 (R9=0x55) -> R9=0 (reset), no done.
//     ext_we during EXEC -> target register unchanged.

Source files
------------

// File: rtl/regbank_exec_ctrl.sv
// regbank_exec_ctrl: 16x32 register bank with a four-state execute sequencer
// that drives an external registered ALU and writes its result back to rd.
`default_nettype none

module regbank_exec_ctrl #(
    parameter int NREG  = 16,
    parameter int DW    = 32,
    parameter int MAXFN = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    instr_valid,
    output logic                    instr_ready,
    input  logic [$clog2(NREG)-1:0] rs,
    input  logic [$clog2(NREG)-1:0] rt,
    input  logic [$clog2(NREG)-1:0] rd,
    input  logic [5:0]              funct_in,
    input  logic [4:0]              shamt_in,
    output logic [DW-1:0]           alu_a,
    output logic [DW-1:0]           alu_b,
    output logic [4:0]              alu_shamt,
    output logic [5:0]              alu_funct,
    input  logic [DW-1:0]           alu_res,
    output logic                    done,
    output logic                    err,
    input  logic                    ext_we,
    input  logic [$clog2(NREG)-1:0] ext_waddr,
    input  logic [DW-1:0]           ext_wdata,
    input  logic [$clog2(NREG)-1:0] dbg_raddr,
    output logic [DW-1:0]           dbg_rdata
);

    localparam int AW = $clog2(NREG);
    localparam logic [5:0] FN_MAX = 6'(MAXFN);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        READ = 2'd1,
        EXEC = 2'd2,
        WB   = 2'd3
    } state_t;

    state_t         state_q;
    logic [DW-1:0]  regs_q [NREG];
    logic [AW-1:0]  rs_q;
    logic [AW-1:0]  rt_q;
    logic [AW-1:0]  rd_q;
    logic [5:0]     funct_q;
    logic [4:0]     shamt_q;
    logic [DW-1:0]  alu_a_q;
    logic [DW-1:0]  alu_b_q;
    logic [4:0]     alu_shamt_q;
    logic [5:0]     alu_funct_q;
    logic           done_q;
    logic           err_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            for (int i = 0; i < NREG; i++) begin
                regs_q[i] <= '0;
            end
            rs_q        <= '0;
            rt_q        <= '0;
            rd_q        <= '0;
            funct_q     <= '0;
            shamt_q     <= '0;
            alu_a_q     <= '0;
            alu_b_q     <= '0;
            alu_shamt_q <= '0;
            alu_funct_q <= '0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            done_q <= 1'b0;
            err_q  <= 1'b0;
            case (state_q)
                IDLE: begin
                    // External write lands at this edge, so an op accepted now reads it in READ.
                    if (ext_we) begin
                        regs_q[ext_waddr] <= ext_wdata;
                    end
                    if (instr_valid) begin
                        rs_q    <= rs;
                        rt_q    <= rt;
                        rd_q    <= rd;
                        funct_q <= funct_in;
                        shamt_q <= shamt_in;
                        if (funct_in > FN_MAX) begin
                            err_q <= 1'b1;
                        end else begin
                            state_q <= READ;
                        end
                    end
                end
                READ: begin
                    alu_a_q     <= regs_q[rs_q];
                    alu_b_q     <= regs_q[rt_q];
                    alu_shamt_q <= shamt_q;
                    alu_funct_q <= funct_q;
                    state_q     <= EXEC;
                end
                EXEC: begin
                    state_q <= WB;
                end
                WB: begin
                    regs_q[rd_q] <= alu_res;
                    done_q       <= 1'b1;
                    state_q      <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign instr_ready = (state_q == IDLE);
    assign alu_a       = alu_a_q;
    assign alu_b       = alu_b_q;
    assign alu_shamt   = alu_shamt_q;
    assign alu_funct   = alu_funct_q;
    assign done        = done_q;
    assign err         = err_q;
    assign dbg_rdata   = regs_q[dbg_raddr];

endmodule

`default_nettype wire

// File: tb/tb_regbank_exec_ctrl.sv
// Directed bench for regbank_exec_ctrl with a small registered ALU model.
`default_nettype none

module tb_regbank_exec_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        instr_valid;
    logic        instr_ready;
    logic [3:0]  rs, rt, rd;
    logic [5:0]  funct_in;
    logic [4:0]  shamt_in;
    logic [31:0] alu_a, alu_b;
    logic [4:0]  alu_shamt;
    logic [5:0]  alu_funct;
    logic [31:0] alu_res;
    logic        done, err;
    logic        ext_we;
    logic [3:0]  ext_waddr;
    logic [31:0] ext_wdata;
    logic [3:0]  dbg_raddr;
    logic [31:0] dbg_rdata;

    int n_checks = 0;
    int n_errors = 0;

    regbank_exec_ctrl dut (
        .clk(clk), .rst(rst),
        .instr_valid(instr_valid), .instr_ready(instr_ready),
        .rs(rs), .rt(rt), .rd(rd), .funct_in(funct_in), .shamt_in(shamt_in),
        .alu_a(alu_a), .alu_b(alu_b), .alu_shamt(alu_shamt), .alu_funct(alu_funct),
        .alu_res(alu_res), .done(done), .err(err),
        .ext_we(ext_we), .ext_waddr(ext_waddr), .ext_wdata(ext_wdata),
        .dbg_raddr(dbg_raddr), .dbg_rdata(dbg_rdata)
    );

    always #5 clk = ~clk;

    // Reference ALU: captures its result on every rising edge.
    always @(posedge clk) begin
        case (alu_funct)
            6'd0: alu_res <= alu_a + alu_b;
            6'd1: alu_res <= alu_a - alu_b;
            6'd2: alu_res <= alu_a & alu_b;
            6'd3: alu_res <= alu_a | alu_b;
            6'd4: alu_res <= alu_a ^ alu_b;
            6'd5: alu_res <= ~alu_a;
            6'd6: alu_res <= alu_a << alu_shamt;
            6'd7: alu_res <= $unsigned($signed(alu_a) >>> alu_shamt);
            6'd8: alu_res <= alu_a >> alu_shamt;
            default: alu_res <= 32'd0;
        endcase
    end

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic read_reg(input logic [3:0] addr, output logic [31:0] val);
        dbg_raddr = addr;
        #1;
        val = dbg_rdata;
    endtask

    task automatic check_reg(input string tag, input logic [3:0] addr, input logic [31:0] exp);
        logic [31:0] v;
        read_reg(addr, v);
        check_eq(tag, v, exp);
    endtask

    task automatic ext_write(input logic [3:0] addr, input logic [31:0] data);
        ext_we = 1'b1; ext_waddr = addr; ext_wdata = data;
        tick();
        ext_we = 1'b0;
    endtask

    task automatic run_op(input string tag, input logic [5:0] fn, input logic [3:0] s,
                          input logic [3:0] t, input logic [3:0] d, input logic [4:0] sh,
                          input logic [31:0] exp_a, input logic [31:0] exp_b,
                          input logic [31:0] exp_res);
        funct_in = fn; rs = s; rt = t; rd = d; shamt_in = sh; instr_valid = 1'b1;
        dbg_raddr = d;
        tick();
        instr_valid = 1'b0;
        check_eq({tag, "_ready_low"}, {31'd0, instr_ready}, 32'd0);
        tick();
        check_eq({tag, "_alu_a"}, alu_a, exp_a);
        check_eq({tag, "_alu_b"}, alu_b, exp_b);
        check_eq({tag, "_alu_shamt"}, {27'd0, alu_shamt}, {27'd0, sh});
        check_eq({tag, "_alu_funct"}, {26'd0, alu_funct}, {26'd0, fn});
        tick();
        check_eq({tag, "_done_early"}, {31'd0, done}, 32'd0);
        tick();
        check_eq({tag, "_done"}, {31'd0, done}, 32'd1);
        check_eq({tag, "_err"}, {31'd0, err}, 32'd0);
        check_eq({tag, "_result"}, dbg_rdata, exp_res);
        tick();
        check_eq({tag, "_done_pulse"}, {31'd0, done}, 32'd0);
    endtask

    initial begin
        int acc [2];
        int nacc;
        bit got_first;

        rst = 1'b1; instr_valid = 1'b0; rs = '0; rt = '0; rd = '0;
        funct_in = '0; shamt_in = '0; ext_we = 1'b0; ext_waddr = '0;
        ext_wdata = '0; dbg_raddr = '0;

        // 1. reset
        tick(); tick();
        rst = 1'b0;
        for (int i = 0; i < 16; i++) begin
            check_reg($sformatf("reset_r%0d", i), 4'(i), 32'd0);
        end
        check_eq("reset_ready", {31'd0, instr_ready}, 32'd1);
        check_eq("reset_done", {31'd0, done}, 32'd0);
        check_eq("reset_err", {31'd0, err}, 32'd0);
        check_eq("reset_alu_a", alu_a, 32'd0);

        // 2. ADD
        ext_write(4'd1, 32'd5);
        ext_write(4'd2, 32'd3);
        run_op("add", 6'd0, 4'd1, 4'd2, 4'd3, 5'd0, 32'd5, 32'd3, 32'd8);

        // 3. SRA / SRL
        ext_write(4'd4, 32'hFFFF_FFF0);
        run_op("sra", 6'd7, 4'd4, 4'd0, 4'd5, 5'd2, 32'hFFFF_FFF0, 32'd0, 32'hFFFF_FFFC);
        run_op("srl", 6'd8, 4'd4, 4'd0, 4'd5, 5'd2, 32'hFFFF_FFF0, 32'd0, 32'h3FFF_FFFC);

        // 4. illegal funct
        funct_in = 6'd9; rs = 4'd1; rt = 4'd2; rd = 4'd1; instr_valid = 1'b1;
        tick();
        instr_valid = 1'b0;
        check_eq("illegal_err", {31'd0, err}, 32'd1);
        check_eq("illegal_ready", {31'd0, instr_ready}, 32'd1);
        check_eq("illegal_done", {31'd0, done}, 32'd0);
        tick(); tick(); tick();
        check_eq("illegal_err_pulse", {31'd0, err}, 32'd0);
        check_reg("illegal_r1", 4'd1, 32'd5);
        check_reg("illegal_r3", 4'd3, 32'd8);
        check_reg("illegal_r5", 4'd5, 32'h3FFF_FFFC);

        // 5. SUB rd==rs, then back-to-back with valid held high
        ext_write(4'd6, 32'd10);
        ext_write(4'd7, 32'd4);
        funct_in = 6'd1; rs = 4'd6; rt = 4'd7; rd = 4'd6; shamt_in = 5'd0;
        dbg_raddr = 4'd6;
        acc[0] = 0; acc[1] = 0; nacc = 0; got_first = 1'b0;
        instr_valid = 1'b1;
        for (int i = 0; i < 12; i++) begin
            if (instr_ready && instr_valid) begin
                if (nacc < 2) acc[nacc] = i;
                nacc++;
            end
            tick();
            if (nacc >= 2) instr_valid = 1'b0;
            if (done && !got_first) begin
                got_first = 1'b1;
                check_eq("sub_first_result", dbg_rdata, 32'd6);
            end
        end
        instr_valid = 1'b0;
        check_eq("b2b_accepts", 32'(nacc), 32'd2);
        check_eq("b2b_spacing", 32'(acc[1] - acc[0]), 32'd4);
        check_eq("sub_first_seen", {31'd0, got_first}, 32'd1);
        check_reg("sub_second_result", 4'd6, 32'd2);

        // 6a. ext_we during EXEC is ignored
        funct_in = 6'd0; rs = 4'd1; rt = 4'd2; rd = 4'd11; instr_valid = 1'b1;
        tick();
        instr_valid = 1'b0;
        tick();
        ext_we = 1'b1; ext_waddr = 4'd12; ext_wdata = 32'hAA;
        tick();
        ext_we = 1'b0;
        tick(); tick();
        check_reg("exec_ext_we_r12", 4'd12, 32'd0);
        check_reg("exec_op_r11", 4'd11, 32'd8);

        // 6b. reset during EXEC aborts the op
        ext_write(4'd9, 32'h55);
        check_reg("pre_reset_r9", 4'd9, 32'h55);
        funct_in = 6'd0; rs = 4'd1; rt = 4'd2; rd = 4'd9; instr_valid = 1'b1;
        tick();
        instr_valid = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_eq("abort_done", {31'd0, done}, 32'd0);
        check_eq("abort_ready", {31'd0, instr_ready}, 32'd1);
        tick();
        check_eq("abort_done_later", {31'd0, done}, 32'd0);
        tick();
        check_eq("abort_done_later2", {31'd0, done}, 32'd0);
        check_reg("abort_r9", 4'd9, 32'd0);
        check_reg("abort_r1", 4'd1, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire
